// File: rtl/frame_diff_tracker_if.sv
// Purpose: pixel-pair input bus and motion result outputs of frame_diff_tracker.
// Latency: none (signal bundle only).
// Backpressure: none; iDVAL qualifies each pixel pair and the consumer always accepts.
// Ports: iGray1/iGray2 pixel pair, iDVAL/iSOF framing, iThreshold;
//        oMask/oMaskValid per-pixel mask, oXMin..oYMax/oCount/oFound/oResultValid per-frame result, oBusy.
interface frame_diff_tracker_if;
    logic [11:0] iGray1;
    logic [11:0] iGray2;
    logic        iDVAL;
    logic        iSOF;
    logic [11:0] iThreshold;
    logic        oMask;
    logic        oMaskValid;
    logic [9:0]  oXMin;
    logic [9:0]  oXMax;
    logic [8:0]  oYMin;
    logic [8:0]  oYMax;
    logic [18:0] oCount;
    logic        oFound;
    logic        oResultValid;
    logic        oBusy;

    modport master (
        output iGray1, iGray2, iDVAL, iSOF, iThreshold,
        input  oMask, oMaskValid, oXMin, oXMax, oYMin, oYMax, oCount, oFound, oResultValid, oBusy
    );

    modport slave (
        input  iGray1, iGray2, iDVAL, iSOF, iThreshold,
        output oMask, oMaskValid, oXMin, oXMax, oYMin, oYMax, oCount, oFound, oResultValid, oBusy
    );
endinterface

// File: rtl/frame_diff_tracker.sv
// Purpose: per-pixel |cur-prev| threshold into a motion mask, plus per-frame bounding box and motion count.
// Latency: mask 2 cycles after the pixel; result pulse 2 cycles after the frame's last pixel.
// Backpressure: none; iDVAL gaps stall the coordinate counters, nothing is ever refused.
// Ports: iCLK, iRST_N (synchronous, active-low); bus = frame_diff_tracker_if.slave.
module frame_diff_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    frame_diff_tracker_if.slave  bus
);
    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST = 9'(V_ACTIVE - 1);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} stateT;

    stateT       state, stateNext;
    logic        pixAccept, frameStart, loadResult, sofIn;
    logic [9:0]  pixX, xCnt;
    logic [8:0]  pixY, yCnt;

    // Stage 1 carries the threshold with the pixel so in-flight pixels of an
    // aborted frame are still masked against the threshold of their own frame.
    logic        s1Valid, s1Acc;
    logic [11:0] s1Diff, s1Thr, thrReg;
    logic [9:0]  s1X;
    logic [8:0]  s1Y;
    logic        motion1;

    logic [12:0] diff13, negDiff;
    logic [11:0] absDiff;

    logic [18:0] accCount, accCountNext;
    logic [9:0]  accXMin, accXMax, accXMinNext, accXMaxNext;
    logic [8:0]  accYMin, accYMax, accYMinNext, accYMaxNext;

    logic        maskR, maskValidR, resultValidR, foundR;
    logic [9:0]  xMinR, xMaxR;
    logic [8:0]  yMinR, yMaxR;
    logic [18:0] countR;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        pixAccept  = 1'b0;
        frameStart = 1'b0;
        loadResult = 1'b0;
        sofIn      = bus.iDVAL & bus.iSOF;
        case (state)
            IDLE: begin
                if (sofIn) begin
                    frameStart = 1'b1;
                    pixAccept  = 1'b1;
                    stateNext  = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.iDVAL) begin
                    pixAccept  = 1'b1;
                    frameStart = bus.iSOF;
                    if (!bus.iSOF && xCnt == X_LAST && yCnt == Y_LAST) stateNext = REPORT;
                end
            end
            REPORT: begin
                // Last pixel sits in stage 1 now; results come from accumulators plus its contribution.
                loadResult = 1'b1;
                stateNext  = IDLE;
                if (sofIn) begin
                    frameStart = 1'b1;
                    pixAccept  = 1'b1;
                    stateNext  = ACCUM;
                end
            end
            default: stateNext = IDLE;
        endcase
        pixX = frameStart ? 10'd0 : xCnt;
        pixY = frameStart ? 9'd0  : yCnt;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (pixAccept) begin
            if (pixX == X_LAST) begin
                xCnt <= '0;
                yCnt <= pixY + 9'd1;
            end else begin
                xCnt <= pixX + 10'd1;
                yCnt <= pixY;
            end
        end
    end

    // 13-bit subtract: sign bit selects which operand was larger.
    always_comb begin
        diff13  = {1'b0, bus.iGray1} - {1'b0, bus.iGray2};
        negDiff = ~diff13 + 13'd1;
        absDiff = diff13[12] ? negDiff[11:0] : diff13[11:0];
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            thrReg     <= '0;
            s1Valid    <= 1'b0;
            s1Acc      <= 1'b0;
            s1Diff     <= '0;
            s1Thr      <= '0;
            s1X        <= '0;
            s1Y        <= '0;
            maskR      <= 1'b0;
            maskValidR <= 1'b0;
        end else begin
            if (frameStart) thrReg <= bus.iThreshold;
            s1Valid    <= bus.iDVAL;
            s1Acc      <= pixAccept;
            s1Diff     <= absDiff;
            s1Thr      <= frameStart ? bus.iThreshold : thrReg;
            s1X        <= pixX;
            s1Y        <= pixY;
            maskR      <= motion1;
            maskValidR <= s1Valid;
        end
    end

    assign motion1 = s1Acc && (s1Diff > s1Thr);

    always_comb begin
        accCountNext = accCount;
        accXMinNext  = accXMin;
        accXMaxNext  = accXMax;
        accYMinNext  = accYMin;
        accYMaxNext  = accYMax;
        if (motion1) begin
            if (accCount != '1) accCountNext = accCount + 19'd1;
            if (s1X < accXMin) accXMinNext = s1X;
            if (s1X > accXMax) accXMaxNext = s1X;
            if (s1Y < accYMin) accYMinNext = s1Y;
            if (s1Y > accYMax) accYMaxNext = s1Y;
        end
    end

    // A frame start wins over accumulation: anything still in stage 1 belongs
    // to the frame being finished or aborted, never to the new one.
    always_ff @(posedge iCLK) begin
        if (!iRST_N || frameStart) begin
            accCount <= '0;
            accXMin  <= X_LAST;
            accXMax  <= '0;
            accYMin  <= Y_LAST;
            accYMax  <= '0;
        end else begin
            accCount <= accCountNext;
            accXMin  <= accXMinNext;
            accXMax  <= accXMaxNext;
            accYMin  <= accYMinNext;
            accYMax  <= accYMaxNext;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            resultValidR <= 1'b0;
            xMinR        <= '0;
            xMaxR        <= '0;
            yMinR        <= '0;
            yMaxR        <= '0;
            countR       <= '0;
            foundR       <= 1'b0;
        end else begin
            resultValidR <= loadResult;
            if (loadResult) begin
                countR <= accCountNext;
                foundR <= accCountNext >= MIN_CNT;
                if (accCountNext == '0) begin
                    xMinR <= '0;
                    xMaxR <= '0;
                    yMinR <= '0;
                    yMaxR <= '0;
                end else begin
                    xMinR <= accXMinNext;
                    xMaxR <= accXMaxNext;
                    yMinR <= accYMinNext;
                    yMaxR <= accYMaxNext;
                end
            end
        end
    end

    assign bus.oMask        = maskR;
    assign bus.oMaskValid   = maskValidR;
    assign bus.oXMin        = xMinR;
    assign bus.oXMax        = xMaxR;
    assign bus.oYMin        = yMinR;
    assign bus.oYMax        = yMaxR;
    assign bus.oCount       = countR;
    assign bus.oFound       = foundR;
    assign bus.oResultValid = resultValidR;
    assign bus.oBusy        = (state == ACCUM);
endmodule
